// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  localparam int NREQ_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-side signals shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int NREQ       = fifo_arb_pkg::NREQ_DEF,
  parameter int DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH_DEF
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_last;
  logic [NREQ-1:0]            req_ready;
  logic                       full;
  logic                       winc;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [NREQ-1:0]            grant;
  logic                       busy;
  logic [7:0]                 beat_cnt;

  // Environment side: producers and the FIFO pointer block.
  modport master (
    output req_valid, req_data, req_last, full,
    input  req_ready, winc, wdata, grant, busy, beat_cnt
  );

  modport slave (
    input  req_valid, req_data, req_last, full,
    output req_ready, winc, wdata, grant, busy, beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit, rotate back.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // conditional/looped assignments, otherwise synthesis infers latches.
    rot    = '0;
    winner = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[(j + int'(ptr)) % N];
    end
    first = rot & (~rot + N'(1));
    for (int j = 0; j < N; j++) begin
      winner[(j + int'(ptr)) % N] = first[j];
    end
    any = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one async-FIFO write port between NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input logic               wclk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  state_e          state;
  logic [NREQ-1:0] grant_q;
  logic [7:0]      beat_cnt_q;
  logic [PW-1:0]   rr_ptr;

  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] acc;
  logic [PW-1:0]   owner_idx;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   pick_ptr;
  logic [7:0]      cnt_inc;
  logic            burst_end;
  logic [NREQ-1:0] winner;
  logic            any_req;

  always_comb begin
    // Reset gates ready so an abandoned burst never writes in the reset cycle.
    ready = (state == ST_BURST && !bus.full && !rst) ? grant_q : '0;
    acc   = bus.req_valid & ready;

    bus.wdata = '0;
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) bus.wdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (grant_q[i]) owner_idx = PW'(i);
    end

    next_ptr  = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
    cnt_inc   = beat_cnt_q + 8'd1;
    burst_end = (|acc) && ((|(acc & bus.req_last)) || (cnt_inc == 8'(MAX_BURST)));
    // At a burst end the search starts just past the current owner.
    pick_ptr  = (state == ST_BURST) ? next_ptr : rr_ptr;
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge wclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q    <= winner;
            beat_cnt_q <= '0;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (burst_end) begin
            rr_ptr     <= next_ptr;
            beat_cnt_q <= '0;
            if (any_req) begin
              grant_q <= winner;
            end else begin
              grant_q <= '0;
              state   <= ST_IDLE;
            end
          end else if (|acc) begin
            beat_cnt_q <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.winc      = |acc;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state == ST_BURST);
  assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester packet queues feed the DUT, a monitor scores every winc.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  logic wclk = 1'b0;
  logic rst  = 1'b1;

  fifo_wr_arbiter_if #(.NREQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NREQ       (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (8)
  ) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  beat_t           src_q[N][$];
  exp_t            sb[$];
  logic [N-1:0]    en = '1;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*DW +: DW]  = src_q[i][0].data;
        bus.req_last[i]           = src_q[i][0].last;
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_data[i*DW +: DW]  = '0;
        bus.req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock: note which beats the edge will accept, retire them, present the next heads.
  task automatic tick();
    logic [N-1:0] acc;
    #1;
    acc = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic push_pkt(input int r, input int n, input logic [DW-1:0] base, input bit with_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + DW'(k);
      b.last = with_last && (k == n - 1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic sb_push(input int r, input logic [DW-1:0] base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = r;
      e.data = base + DW'(k);
      sb.push_back(e);
    end
  endtask

  function automatic int pending();
    int p;
    p = sb.size();
    for (int i = 0; i < N; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (pending() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, pending(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Scoreboard monitor: every write strobe must match the next expected beat and owner.
  always @(negedge wclk) begin
    exp_t         e;
    logic [N-1:0] g;
    if (bus.winc) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_winc: got wdata %0h grant %b with no beat expected (t=%0t)",
                 bus.wdata, bus.grant, $time);
      end else begin
        e = sb.pop_front();
        g = '0;
        g[e.idx] = 1'b1;
        check("wdata", 32'(bus.wdata), 32'(e.data));
        check("grant_at_winc", 32'(bus.grant), 32'(g));
      end
    end else begin
      check("wdata_idle", 32'(bus.wdata), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.full = 1'b0;
    drive();
    tick();
    rst = 1'b0;
    #1;
    check("reset_grant",    32'(bus.grant),     0);
    check("reset_busy",     32'(bus.busy),      0);
    check("reset_beat_cnt", 32'(bus.beat_cnt),  0);
    check("reset_winc",     32'(bus.winc),      0);
    check("reset_wdata",    32'(bus.wdata),     0);
    check("reset_ready",    32'(bus.req_ready), 0);

    // Two single-beat packets from 1 and 2: back-to-back grants, no idle cycle.
    push_pkt(1, 1, 8'h11, 1'b1);
    push_pkt(2, 1, 8'h21, 1'b1);
    sb_push(1, 8'h11, 1);
    sb_push(2, 8'h21, 1);
    drive();
    tick();
    check("t1_grant1", 32'(bus.grant), 32'h2);
    check("t1_busy",   32'(bus.busy),  1);
    check("t1_winc1",  32'(bus.winc),  1);
    tick();
    check("t1_grant2", 32'(bus.grant), 32'h4);
    check("t1_winc2",  32'(bus.winc),  1);
    tick();
    check("t1_held_grant", 32'(bus.grant),    32'h4);
    check("t1_held_busy",  32'(bus.busy),     1);
    check("t1_held_winc",  32'(bus.winc),     0);
    check("t1_held_cnt",   32'(bus.beat_cnt), 0);
    drain("t1_drained", 4);

    // All four requesters, single-beat packets: order 0,1,2,3,0,1,2,3 at one beat per cycle.
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 1, 8'hA0 + 8'(r), 1'b1);
      push_pkt(r, 1, 8'hB0 + 8'(r), 1'b1);
    end
    for (int r = 0; r < N; r++) sb_push(r, 8'hA0 + 8'(r), 1);
    for (int r = 0; r < N; r++) sb_push(r, 8'hB0 + 8'(r), 1);
    drive();
    tick();
    check("t2_first_grant", 32'(bus.grant), 32'h1);
    for (int k = 0; k < 2 * N; k++) begin
      check("t2_winc_each_cycle", 32'(bus.winc), 1);
      tick();
    end
    drain("t2_drained", 4);

    // Requester 2 sends 12 beats without last: forced release after 8, then 3 and 0 are served.
    do_reset();
    push_pkt(2, 12, 8'h20, 1'b0);
    push_pkt(3, 1, 8'h3C, 1'b1);
    push_pkt(0, 1, 8'h0C, 1'b1);
    sb_push(2, 8'h20, 8);
    sb_push(3, 8'h3C, 1);
    sb_push(0, 8'h0C, 1);
    sb_push(2, 8'h28, 4);
    en = 4'b0100;
    drive();
    tick();
    check("t3_grant2", 32'(bus.grant), 32'h4);
    en = '1;
    drive();
    #1;
    repeat (7) tick();
    check("t3_cnt7",         32'(bus.beat_cnt), 7);
    check("t3_still_grant2", 32'(bus.grant),    32'h4);
    tick();
    check("t3_release_grant3", 32'(bus.grant),    32'h8);
    check("t3_release_cnt0",   32'(bus.beat_cnt), 0);
    drain("t3_drained", 20);
    check("t3_resume_grant2", 32'(bus.grant),    32'h4);
    check("t3_resume_cnt4",   32'(bus.beat_cnt), 4);

    // full held for 5 cycles mid-burst: owner stalls, nothing lost or duplicated.
    do_reset();
    push_pkt(1, 6, 8'h50, 1'b1);
    sb_push(1, 8'h50, 6);
    drive();
    tick();
    tick();
    tick();
    check("t4_cnt_before_full", 32'(bus.beat_cnt), 2);
    bus.full = 1'b1;
    repeat (5) begin
      #1;
      check("t4_ready_full", 32'(bus.req_ready), 0);
      check("t4_winc_full",  32'(bus.winc),      0);
      tick();
      check("t4_grant_held", 32'(bus.grant),    32'h2);
      check("t4_cnt_held",   32'(bus.beat_cnt), 2);
    end
    bus.full = 1'b0;
    #1;
    check("t4_ready_resume", 32'(bus.req_ready), 32'h2);
    drain("t4_drained", 20);

    // Reset on the third beat: packet abandoned, then 0 beats 3 on a fresh pointer.
    do_reset();
    push_pkt(1, 4, 8'h60, 1'b1);
    sb_push(1, 8'h60, 2);
    drive();
    tick();
    tick();
    tick();
    check("t5_cnt2", 32'(bus.beat_cnt), 2);
    rst = 1'b1;
    #1;
    check("t5_winc_in_reset", 32'(bus.winc), 0);
    tick();
    rst = 1'b0;
    src_q[1].delete();
    drive();
    #1;
    check("t5_grant_after_rst", 32'(bus.grant), 0);
    check("t5_busy_after_rst",  32'(bus.busy),  0);
    check("t5_winc_after_rst",  32'(bus.winc),  0);
    push_pkt(3, 1, 8'h73, 1'b1);
    push_pkt(0, 1, 8'h70, 1'b1);
    sb_push(0, 8'h70, 1);
    sb_push(3, 8'h73, 1);
    drive();
    tick();
    check("t5_grant0_first", 32'(bus.grant), 32'h1);
    drain("t5_drained", 6);

    // Sole requester 1 with three packets: re-granted at each packet end without a bubble.
    do_reset();
    push_pkt(1, 2, 8'h80, 1'b1);
    push_pkt(1, 2, 8'h82, 1'b1);
    push_pkt(1, 2, 8'h84, 1'b1);
    sb_push(1, 8'h80, 6);
    drive();
    tick();
    for (int k = 0; k < 6; k++) begin
      check("t6_grant1", 32'(bus.grant), 32'h2);
      check("t6_winc",   32'(bus.winc),  1);
      tick();
    end
    check("t6_regrant_idle_owner", 32'(bus.grant), 32'h2);
    drain("t6_drained", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
